// File: rtl/ws2812_frame_sequencer_if.sv
// Pixel stream between the frame sequencer (master) and the WS2812 bit serializer (slave).
interface ws2812_frame_sequencer_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;

    modport master (output pix_valid, red, green, blue, input pix_ready);
    modport slave  (input pix_valid, red, green, blue, output pix_ready);
endinterface

// File: rtl/ws2812_frame_sequencer.sv
// Double-buffered frame sequencer: streams the front pixel bank to the WS2812 serializer on each refresh tick.
// Optional: define WS_BLANK_ON_DISABLE_EN to send one all-zero frame after i_enable falls.
module ws2812_frame_sequencer #(
    parameter int NUM_LEDS         = 16,
    parameter int ADDR_W           = 5,
    parameter int FRAME_PERIOD_CYC = 1666666,
    parameter int PER_CNT_W        = 21
) (
    input  logic                    i_clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    input  logic                    i_wr_en,
    input  logic [ADDR_W-1:0]       i_wr_addr,
    input  logic [23:0]             i_wr_rgb,
    input  logic                    i_commit,
    output logic                    o_commit_pending,
    ws2812_frame_sequencer_if.master pix,
    input  logic                    i_ser_idle,
    output logic                    o_frame_start,
    output logic                    o_busy,
    output logic                    o_overrun,
    output logic [15:0]             o_frame_cnt
);
    localparam int DEPTH = 2 * NUM_LEDS;
    localparam int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0]    LAST_IDX = ADDR_W'(NUM_LEDS - 1);
    localparam logic [PER_CNT_W-1:0] PER_LAST = PER_CNT_W'(FRAME_PERIOD_CYC - 1);

    typedef enum logic [2:0] {IDLE, START, FETCH, PRESENT, DRAIN} state_t;

    state_t                state;
    logic [PER_CNT_W-1:0]  per_cnt;
    logic                  front;
    logic                  pend;
    logic                  pix_valid;
    logic [ADDR_W-1:0]     idx;
    logic [23:0]           mem [DEPTH];
    logic [23:0]           rd_q;
    logic [MAW-1:0]        rd_addr;
    logic [MAW-1:0]        wr_addr;
    logic                  tick;
    logic                  wr_ok;

`ifdef WS_BLANK_ON_DISABLE_EN
    logic en_q;
    logic blank_req;
    logic blank;
`else
    logic blank_req;
    logic blank;
    assign blank_req = 1'b0;
    assign blank     = 1'b0;
`endif

    assign tick    = i_enable && (per_cnt == PER_LAST);
    // The back bank freezes once a swap is requested so the committed image stays intact.
    assign wr_ok   = i_wr_en && !pend && (int'(i_wr_addr) < NUM_LEDS);
    assign rd_addr = MAW'(int'(idx) + (front ? NUM_LEDS : 0));
    assign wr_addr = MAW'(int'(i_wr_addr) + (front ? 0 : NUM_LEDS));

    assign o_commit_pending = pend;
    assign pix.pix_valid    = pix_valid;
    assign {pix.red, pix.green, pix.blue} = (pix_valid && !blank) ? rd_q : 24'h0;

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[wr_addr] <= i_wr_rgb;
        if (state == FETCH) rd_q <= mem[rd_addr];
    end

    always_ff @(posedge i_clk) begin
        if (rst_n) begin
            state         <= IDLE;
            per_cnt       <= '0;
            front         <= 1'b0;
            pend          <= 1'b0;
            idx           <= '0;
            pix_valid     <= 1'b0;
            o_frame_start <= 1'b0;
            o_busy        <= 1'b0;
            o_overrun     <= 1'b0;
            o_frame_cnt   <= '0;
`ifdef WS_BLANK_ON_DISABLE_EN
            en_q          <= 1'b0;
            blank_req     <= 1'b0;
            blank         <= 1'b0;
`endif
        end else begin
            o_frame_start <= 1'b0;
            if (!i_enable || tick) per_cnt <= '0;
            else                   per_cnt <= per_cnt + 1'b1;
            if (tick && state != IDLE) o_overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (tick || blank_req) begin
                        state         <= START;
                        o_frame_start <= 1'b1;
                        o_busy        <= 1'b1;
`ifdef WS_BLANK_ON_DISABLE_EN
                        blank         <= blank_req;
                        blank_req     <= 1'b0;
`endif
                    end
                end
                START: begin
                    idx   <= '0;
                    state <= FETCH;
                    if (pend && !blank) begin
                        front <= ~front;
                        pend  <= 1'b0;
                    end
                end
                FETCH: begin
                    state     <= PRESENT;
                    pix_valid <= 1'b1;
                end
                PRESENT: begin
                    if (pix.pix_ready) begin
                        pix_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= DRAIN;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (i_ser_idle) begin
                        o_frame_cnt <= o_frame_cnt + 16'd1;
                        if (blank_req) begin
                            // Blank frame follows immediately, without waiting for a tick.
                            state         <= START;
                            o_frame_start <= 1'b1;
`ifdef WS_BLANK_ON_DISABLE_EN
                            blank         <= 1'b1;
                            blank_req     <= 1'b0;
`endif
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
`ifdef WS_BLANK_ON_DISABLE_EN
                            blank  <= 1'b0;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after START so a commit in that same cycle survives to the next frame.
            if (i_commit) pend <= 1'b1;
`ifdef WS_BLANK_ON_DISABLE_EN
            en_q <= i_enable;
            if (en_q && !i_enable) blank_req <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Bench for ws2812_frame_sequencer: host-op vector table, pixel scoreboard, and hand sequences for stall/overrun/disable/reset.
`timescale 1ns/1ps
module tb_ws2812_frame_sequencer;
    localparam int NL = 4;
    localparam int AW = 3;
    localparam int FP = 200;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          wr_en = 1'b0;
    logic          commit = 1'b0;
    logic          ser_idle = 1'b1;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_rgb = '0;
    logic          commit_pending, frame_start, busy, overrun;
    logic [15:0]   frame_cnt;

    ws2812_frame_sequencer_if pix_if();

    ws2812_frame_sequencer #(
        .NUM_LEDS(NL), .ADDR_W(AW), .FRAME_PERIOD_CYC(FP), .PER_CNT_W(PW)
    ) dut (
        .i_clk(clk), .rst_n(rst), .i_enable(en),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_rgb(wr_rgb),
        .i_commit(commit), .o_commit_pending(commit_pending),
        .pix(pix_if.master), .i_ser_idle(ser_idle),
        .o_frame_start(frame_start), .o_busy(busy),
        .o_overrun(overrun), .o_frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [23:0] sb[$];
    logic [23:0] mbank[2][NL];
    int          mfront = 0;
    bit          mpend = 1'b0;
    int          mcnt = 0;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [23:0]   rgb;
        logic          cm;
        logic          exp_pend;
        logic          frame;
    } vec_t;
    vec_t vt[13];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every accepted pixel must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && pix_if.pix_valid && pix_if.pix_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got pixel %0h expected none", {pix_if.red, pix_if.green, pix_if.blue});
            end else begin
                chk("pixel", 32'({pix_if.red, pix_if.green, pix_if.blue}), 32'(sb.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_op(input logic wr, input logic [AW-1:0] a, input logic [23:0] rgb, input logic cm);
        wr_en = wr; wr_addr = a; wr_rgb = rgb; commit = cm;
        step();
        wr_en = 1'b0; commit = 1'b0;
        if (wr && int'(a) < NL && !mpend) mbank[1 - mfront][a] = rgb;
        if (cm) mpend = 1'b1;
    endtask

    task automatic wait_fs(output int c);
        int n = 0;
        while (!frame_start && n < 600) begin step(); n++; end
        chk("frame_start_seen", 32'(frame_start), 32'd1);
        c = cyc;
        if (frame_start) begin
            if (mpend) begin mfront = 1 - mfront; mpend = 1'b0; end
            for (int i = 0; i < NL; i++) sb.push_back(mbank[mfront][i]);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!pix_if.pix_valid && n < 20) begin step(); n++; end
        chk("valid_seen", 32'(pix_if.pix_valid), 32'd1);
    endtask

    task automatic finish_frame();
        int n = 0;
        while (busy && n < 400) begin step(); n++; end
        chk("frame_done", 32'(busy), 32'd0);
        mcnt++;
        chk("frame_cnt", 32'(frame_cnt), 32'(mcnt));
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_frame();
        int c;
        wait_fs(c);
        step();
        chk("fs_width", 32'(frame_start), 32'd0);
        finish_frame();
    endtask

    initial begin
        int c1, c2, fs_cnt;
        vt[0]  = '{1'b1, 3'd0, 24'h110000, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 3'd1, 24'h002200, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 3'd2, 24'h000033, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 3'd3, 24'hFFFFFF, 1'b1, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 3'd1, 24'h123456, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 3'd0, 24'h000000, 1'b0, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 3'd0, 24'h010203, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 3'd1, 24'hABCDEF, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 3'd2, 24'h040506, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 3'd3, 24'h0A0B0C, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b1, 3'd7, 24'h777777, 1'b0, 1'b0, 1'b1};
        vt[11] = '{1'b0, 3'd0, 24'h000000, 1'b1, 1'b1, 1'b0};
        vt[12] = '{1'b1, 3'd2, 24'h555555, 1'b0, 1'b1, 1'b1};

        pix_if.pix_ready = 1'b1;
        repeat (3) step();
        chk("rst_valid",   32'(pix_if.pix_valid), 32'd0);
        chk("rst_rgb",     32'({pix_if.red, pix_if.green, pix_if.blue}), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_fs",      32'(frame_start), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_pending", 32'(commit_pending), 32'd0);
        chk("rst_cnt",     32'(frame_cnt), 32'd0);
        rst = 1'b0;
        en  = 1'b1;

        for (int i = 0; i < 13; i++) begin
            host_op(vt[i].wr, vt[i].addr, vt[i].rgb, vt[i].cm);
            chk("pending", 32'(commit_pending), 32'(vt[i].exp_pend));
            if (vt[i].frame) run_frame();
        end

        // Serializer stalls on pixel 2: data must hold steady and nothing is skipped or repeated.
        pix_if.pix_ready = 1'b0;
        wait_fs(c1);
        for (int p = 0; p < NL; p++) begin
            wait_valid();
            if (p == 2) begin
                repeat (10) begin
                    step();
                    chk("stall_valid", 32'(pix_if.pix_valid), 32'd1);
                    chk("stall_rgb", 32'({pix_if.red, pix_if.green, pix_if.blue}), 32'(mbank[mfront][2]));
                end
            end
            pix_if.pix_ready = 1'b1;
            step();
            pix_if.pix_ready = 1'b0;
        end
        finish_frame();
        pix_if.pix_ready = 1'b1;

        // Long drain swallows one tick; the next frame waits for the following tick.
        ser_idle = 1'b0;
        wait_fs(c1);
        repeat (300) step();
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("drain_busy",  32'(busy), 32'd1);
        chk("drain_cnt",   32'(frame_cnt), 32'(mcnt));
        ser_idle = 1'b1;
        finish_frame();
        wait_fs(c2);
        chk("tick_after_overrun", 32'(c2 - c1), 32'(2 * FP));
        finish_frame();
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Disable mid-frame: the frame completes, then no more frames.
        wait_fs(c1);
        en = 1'b0;
        finish_frame();
        fs_cnt = 0;
        repeat (450) begin
            step();
            if (frame_start) fs_cnt++;
        end
        chk("no_start_disabled", 32'(fs_cnt), 32'd0);

        // Reset in PRESENT aborts at once.
        en = 1'b1;
        pix_if.pix_ready = 1'b0;
        wait_fs(c1);
        wait_valid();
        rst = 1'b1;
        step();
        chk("abort_valid",   32'(pix_if.pix_valid), 32'd0);
        chk("abort_busy",    32'(busy), 32'd0);
        chk("abort_cnt",     32'(frame_cnt), 32'd0);
        chk("abort_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        sb.delete();
        pix_if.pix_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ws2812_frame_sequencer.md
Name: ws2812_frame_sequencer

Overview:
- Frame-level controller for the WS2812 bit serializer.
- Holds a double-buffered pixel RAM of NUM_LEDS x 24-bit RGB words, written by the host.
- At a fixed refresh rate it streams the front buffer pixel-by-pixel to the serializer over a valid/ready handshake.
- Swaps buffers only on frame boundaries, so a displayed frame is never torn.

Parameters:
- NUM_LEDS, 16: LEDs per strip (pixels per frame), 1..2**ADDR_W.
- ADDR_W, 5: pixel address width.
- FRAME_PERIOD_CYC, 1666666: i_clk cycles per refresh tick (60 Hz at 100 MHz).
- PER_CNT_W, 21: width of the period counter; must hold FRAME_PERIOD_CYC-1.

Ports:
- i_clk, input, 1: system clock, 100 MHz.
- rst_n, input, 1: synchronous, active-high reset (the name is historical; asserted = 1).
- i_enable, input, 1: run refresh; 0 = stop after the current frame.
- i_wr_en, input, 1: host pixel write strobe.
- i_wr_addr, input, ADDR_W: pixel index to write.
- i_wr_rgb, input, 24: {R[23:16], G[15:8], B[7:0]} written to the back bank.
- i_commit, input, 1: request a front/back swap at the next frame start.
- o_commit_pending, output, 1: a swap is requested and not yet taken.
- o_pix_valid, output, 1: pixel presented to the serializer.
- i_pix_ready, input, 1: serializer accepts the pixel.
- o_red / o_green / o_blue, output, 8 each: pixel colour.
- i_ser_idle, input, 1: serializer has finished the last bit and the reset/latch period.
- o_frame_start, output, 1: one-cycle pulse when a frame begins.
- o_busy, output, 1: a frame is in progress.
- o_overrun, output, 1: sticky; a tick arrived while a frame was still busy.
- o_frame_cnt, output, 16: frames completed, wraps at 65535 -> 0.

Behaviour:
- Reset (rst_n=1, sampled on i_clk rising edge):
  - FSM -> IDLE; front bank = 0.
  - All outputs 0; period counter 0.
  - RAM contents are not cleared.
  - Reset mid-frame aborts immediately, with o_pix_valid=0 on the next cycle.
- Period counter:
  - Runs only while i_enable=1 and counts 0..FRAME_PERIOD_CYC-1.
  - The tick is the terminal-count cycle.
  - Counter is cleared while i_enable=0.
- FSM states: IDLE, START, FETCH, PRESENT, DRAIN.
  - IDLE: on tick with i_enable=1 -> START.
  - START (1 cycle):
    - Pulse o_frame_start; o_busy=1; pixel index = 0.
    - If o_commit_pending, toggle the front bank and clear pending.
    - -> FETCH.
  - FETCH (1 cycle): issue the registered RAM read of the front bank at the index -> PRESENT.
  - PRESENT:
    - Assert o_pix_valid with RGB held stable until i_pix_ready=1.
    - On transfer: if index == NUM_LEDS-1 -> DRAIN, else index+1 -> FETCH.
    - Minimum 2 cycles per pixel.
  - DRAIN:
    - Wait for i_ser_idle=1, then increment o_frame_cnt, o_busy=0 -> IDLE.
- Disable: i_enable=0 during a frame never truncates it; the frame completes, then the FSM stays in IDLE.
- Overrun:
  - A tick while the FSM is not in IDLE sets o_overrun; the tick is dropped.
  - o_overrun clears only on reset.
- Host writes:
  - A write goes to the back bank (the non-front bank) in the same cycle.
  - i_wr_addr >= NUM_LEDS: ignored.
  - Writes while o_commit_pending=1 are ignored (the back bank is frozen until the swap).
  - A write in the same cycle as i_commit is accepted.
- Commit:
  - i_commit sets o_commit_pending the next cycle.
  - Repeated commits while pending have no extra effect.
  - Commit in the same cycle as START is taken at the following frame.
- RAM: 2*NUM_LEDS x 24, inferred, 1 write and 1 read port, registered read.

Optional Feature:
- Macro: WS_BLANK_ON_DISABLE_EN.
- Defined: when i_enable falls, after the current frame completes, one extra frame of all-zero pixels is sent (no tick wait, no swap, counts in o_frame_cnt), then the FSM goes to IDLE. If i_enable returns during the blank frame, the blank frame still completes.
- Undefined: the LEDs hold their last frame; behaviour is exactly as above.

Test Plan:
- NUM_LEDS=4, FRAME_PERIOD_CYC=200, write addr0..3 = 0x110000, 0x002200, 0x000033, 0xFFFFFF, commit, i_pix_ready tied 1 -> the frame after the next tick shows the 4 pixels in order; o_frame_start is 1 cycle wide; o_frame_cnt=1 after i_ser_idle.
- i_pix_ready held 0 for 10 cycles on pixel 2 -> o_pix_valid stays high and RGB is unchanged; no pixel skipped or duplicated.
- Write addr1 = 0xABCDEF without commit -> the next frame still shows 0x002200 at pixel 1; after commit, the following frame shows 0xABCDEF.
- Write during o_commit_pending -> ignored; write to addr 7 -> ignored; RAM readback unchanged.
- Hold i_ser_idle=0 for 300 cycles in DRAIN -> o_overrun=1; next frame starts only on the tick after returning to IDLE.
- Assert rst_n mid-PRESENT -> next cycle o_pix_valid=0, o_busy=0, o_frame_cnt=0; with i_enable=0 mid-frame, the frame completes and no further o_frame_start occurs.
